// File: rtl/counter_access_arbiter.sv
// counter_access_arbiter
// Shares one 3-bit load/increment counter between two requesters.
// Requests are served one at a time, round-robin on contention, and an
// increment is refused (nack) instead of issued when the counter already
// sits at SAT_VALUE.
//
// Handshake: a requester raises reqN with opN/dataN stable and holds them
// until it sees a one-cycle gntN (operation performed) or nackN (increment
// refused). Requests are sampled only in IDLE; a transaction takes IDLE ->
// ISSUE -> RESPOND, so ld/inc appear one cycle after sampling and gnt/nack
// one cycle after that, when data_out already shows the new counter value.
module counter_access_arbiter #(
  parameter logic [2:0] SAT_VALUE = 3'h7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       op0,
  input  logic [2:0] data0,
  output logic       gnt0,
  output logic       nack0,
  input  logic       req1,
  input  logic       op1,
  input  logic [2:0] data1,
  output logic       gnt1,
  output logic       nack1,
  output logic       ld,
  output logic       inc,
  output logic [2:0] data_in,
  input  logic [2:0] data_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       prio_q, prio_d;        // port preferred on contention
  logic       sel_q, sel_d;          // port being served
  logic       op_q, op_d;            // 1 = load, 0 = increment
  logic [2:0] data_q, data_d;        // latched load value
  logic       refused_q, refused_d;  // increment refused at saturation
  logic [2:0] data_in_q, data_in_d;  // data_in holds its last load value

  // Next-state and output decode for the IDLE/ISSUE/RESPOND sequence.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    sel_d     = sel_q;
    op_d      = op_q;
    data_d    = data_q;
    refused_d = refused_q;
    data_in_d = data_in_q;
    ld        = 1'b0;
    inc       = 1'b0;
    data_in   = data_in_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    nack0     = 1'b0;
    nack1     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Single requester wins outright; on contention the pointer decides.
          sel_d     = (req0 && req1) ? prio_q : req1;
          op_d      = sel_d ? op1 : op0;
          data_d    = sel_d ? data1 : data0;
          refused_d = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (op_q) begin
          // Loads are always allowed, even at saturation.
          ld        = 1'b1;
          data_in   = data_q;
          data_in_d = data_q;
        end else if (data_out != SAT_VALUE) begin
          inc = 1'b1;
        end else begin
          refused_d = 1'b1;
        end
        state_d = RESPOND;
      end
      RESPOND: begin
        if (refused_q) begin
          nack0 = ~sel_q;
          nack1 = sel_q;
        end else begin
          gnt0 = ~sel_q;
          gnt1 = sel_q;
        end
        // Served port loses priority whether it was granted or refused.
        prio_d  = ~sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // State and latched-transaction registers; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      sel_q     <= 1'b0;
      op_q      <= 1'b0;
      data_q    <= 3'h0;
      refused_q <= 1'b0;
      data_in_q <= 3'h0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      sel_q     <= sel_d;
      op_q      <= op_d;
      data_q    <= data_d;
      refused_q <= refused_d;
      data_in_q <= data_in_d;
    end
  end

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Bench for counter_access_arbiter: directed scenarios plus random traffic,
// with a transaction-level model predicting every output cycle by cycle.
module tb_counter_access_arbiter;

  localparam logic [2:0] SAT = 3'h7;
  localparam int REC_W = 13;

  typedef struct packed {
    logic       busy;
    logic       ld;
    logic       inc;
    logic [2:0] din;
    logic       g0;
    logic       g1;
    logic       n0;
    logic       n1;
    logic [2:0] dout;
  } rec_t;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
  logic [2:0] data0 = 3'h0, data1 = 3'h0;
  logic       gnt0, nack0, gnt1, nack1, ld, inc, busy;
  logic [2:0] data_in;
  logic [2:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  counter_access_arbiter #(.SAT_VALUE(SAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .data0(data0), .gnt0(gnt0), .nack0(nack0),
    .req1(req1), .op1(op1), .data1(data1), .gnt1(gnt1), .nack1(nack1),
    .ld(ld), .inc(inc), .data_in(data_in), .data_out(data_out), .busy(busy)
  );

  // The counter instance the arbiter drives.
  always @(posedge clk) begin
    if (!rst)     data_out <= 3'h0;
    else if (ld)  data_out <= data_in;
    else if (inc) data_out <= data_out + 3'h1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [REC_W-1:0] exp_q[$];
  rec_t       cur;
  logic       started = 1'b0;
  int         m_prio = 0;
  logic [2:0] m_din = 3'h0;
  logic [2:0] m_cnt = 3'h0;

  function automatic rec_t idle_rec(input logic [2:0] din, input logic [2:0] cnt);
    rec_t r;
    r = '0;
    r.din  = din;
    r.dout = cnt;
    return r;
  endfunction

  // Transaction model: when the arbiter is free and someone asks, decide the
  // whole outcome at once and queue the two cycles it will take.
  always @(posedge clk) begin
    int         port;
    logic       mop, refused;
    logic [2:0] d, old;
    rec_t       r1, r2;
    started = 1'b1;
    if (!rst) begin
      exp_q.delete();
      m_prio = 0;
      m_din  = 3'h0;
      m_cnt  = 3'h0;
      cur    = idle_rec(m_din, m_cnt);
    end else begin
      if (!cur.busy && (req0 || req1)) begin
        port    = (req0 && req1) ? m_prio : (req1 ? 1 : 0);
        mop     = (port == 1) ? op1 : op0;
        d       = (port == 1) ? data1 : data0;
        old     = m_cnt;
        refused = 1'b0;
        if (mop) begin
          m_din = d;
          m_cnt = d;
        end else if (m_cnt == SAT) begin
          refused = 1'b1;
        end else begin
          m_cnt = m_cnt + 3'h1;
        end
        r1 = idle_rec(m_din, old);
        r1.busy = 1'b1;
        r1.ld   = mop;
        r1.inc  = !mop && !refused;
        r2 = idle_rec(m_din, m_cnt);
        r2.busy = 1'b1;
        r2.g0 = (port == 0) && !refused;
        r2.g1 = (port == 1) && !refused;
        r2.n0 = (port == 0) && refused;
        r2.n1 = (port == 1) && refused;
        exp_q.push_back(REC_W'(r1));
        exp_q.push_back(REC_W'(r2));
        m_prio = 1 - port;
      end
      if (exp_q.size() > 0) cur = rec_t'(exp_q.pop_front());
      else                  cur = idle_rec(m_din, m_cnt);
    end
  end

  // Compare every cycle, mid-cycle away from the active edge.
  always @(negedge clk) begin
    rec_t act;
    if (started) begin
      act = {busy, ld, inc, data_in, gnt0, gnt1, nack0, nack1, data_out};
      check("cycle_outputs", int'(act), int'(cur));
      check("firewall_inc_at_sat", int'(inc && (data_out == SAT)), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int port, input logic r, input logic op, input logic [2:0] d);
    if (port == 0) begin req0 = r; op0 = op; data0 = d; end
    else           begin req1 = r; op1 = op; data1 = d; end
  endtask

  task automatic do_op(input int port, input logic op, input logic [2:0] d,
                       output int res, output int lat, output logic saw_ld,
                       output logic saw_inc, output logic [2:0] din_seen,
                       output logic [2:0] dout_seen);
    @(negedge clk);
    set_req(port, 1'b1, op, d);
    res = 0; lat = 0; saw_ld = 1'b0; saw_inc = 1'b0; din_seen = 3'h0; dout_seen = 3'h0;
    for (int i = 1; i <= 20 && res == 0; i++) begin
      @(negedge clk);
      if (ld) begin saw_ld = 1'b1; din_seen = data_in; end
      if (inc) saw_inc = 1'b1;
      if ((port == 0) ? gnt0 : gnt1)       res = 1;
      else if ((port == 0) ? nack0 : nack1) res = 2;
      if (res != 0) begin lat = i; dout_seen = data_out; end
    end
    set_req(port, 1'b0, op, d);
    check("op_response_seen", int'(res != 0), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         res, lat, first;
    logic       sld, sinc;
    logic [2:0] din_s, dout_s;
    int         order[$];
    logic [2:0] vals[$];
    int         stamps[$];

    // Reset held with both ports requesting.
    req0 = 1'b1; req1 = 1'b1; op0 = 1'b0; op1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_idle_outputs", int'({ld, inc, gnt0, gnt1, nack0, nack1, busy}), 0);
    check("reset_data_in", int'(data_in), 0);
    rst = 1'b1;
    first = -1;
    for (int i = 0; i < 10 && first < 0; i++) begin
      @(negedge clk);
      if (gnt0) first = 0;
      else if (gnt1) first = 1;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("reset_port0_first", first, 0);

    // Single load of 5.
    do_op(0, 1'b1, 3'h5, res, lat, sld, sinc, din_s, dout_s);
    check("load5_gnt", res, 1);
    check("load5_latency", lat, 2);
    check("load5_ld_seen", int'(sld), 1);
    check("load5_data_in", int'(din_s), 5);
    check("load5_data_out", int'(dout_s), 5);

    // Saturation: load 6, increment to 7, increment refused.
    do_op(0, 1'b1, 3'h6, res, lat, sld, sinc, din_s, dout_s);
    check("load6_data_out", int'(dout_s), 6);
    do_op(1, 1'b0, 3'h0, res, lat, sld, sinc, din_s, dout_s);
    check("inc6_gnt", res, 1);
    check("inc6_inc_seen", int'(sinc), 1);
    check("inc6_data_out", int'(dout_s), 7);
    do_op(1, 1'b0, 3'h0, res, lat, sld, sinc, din_s, dout_s);
    check("inc7_nack", res, 2);
    check("inc7_latency", lat, 2);
    check("inc7_no_inc", int'(sinc), 0);
    check("inc7_data_out", int'(dout_s), 7);

    // Load at saturation, then increment.
    do_op(0, 1'b1, 3'h2, res, lat, sld, sinc, din_s, dout_s);
    check("load_at_sat_gnt", res, 1);
    check("load_at_sat_data_out", int'(dout_s), 2);
    do_op(0, 1'b0, 3'h0, res, lat, sld, sinc, din_s, dout_s);
    check("inc2_gnt", res, 1);
    check("inc2_data_out", int'(dout_s), 3);

    // Contention: load 0 through port 1 (pointer then favours port 0),
    // then both ports hold increment requests.
    do_op(1, 1'b1, 3'h0, res, lat, sld, sinc, din_s, dout_s);
    check("load0_data_out", int'(dout_s), 0);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 3'h0);
    set_req(1, 1'b1, 1'b0, 3'h0);
    for (int i = 0; i < 30 && order.size() < 4; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        order.push_back(gnt1 ? 1 : 0);
        vals.push_back(data_out);
        stamps.push_back(cyc);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_grant_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      check("rr_order", order[i], i % 2);
      check("rr_value", int'(vals[i]), i + 1);
      if (i > 0) check("rr_spacing", stamps[i] - stamps[i-1], 3);
    end

    // Requester drops req during ISSUE: operation still completes.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 3'h4);
    @(negedge clk);
    check("drop_issue_ld", int'(ld), 1);
    req0 = 1'b0;
    @(negedge clk);
    check("drop_issue_gnt0", int'(gnt0), 1);
    check("drop_issue_data_out", int'(data_out), 4);

    // Reset during ISSUE of a load 3: no response, back to idle.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 3'h3);
    @(negedge clk);
    check("rst_mid_ld", int'(ld), 1);
    rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    check("rst_mid_no_gnt", int'({gnt0, nack0}), 0);
    check("rst_mid_busy", int'(busy), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_after_busy", int'(busy), 0);
    check("rst_mid_after_gnt", int'(gnt0), 0);

    // Random traffic: each port follows the hold-until-response rule.
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      if (req0) begin
        if (gnt0 || nack0) req0 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        set_req(0, 1'b1, ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)));
      end
      if (req1) begin
        if (gnt1 || nack1) req1 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        set_req(1, 1'b1, ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)));
      end
    end
    // Let outstanding requests finish before stopping.
    for (int i = 0; i < 20 && (req0 || req1); i++) begin
      @(negedge clk);
      if (gnt0 || nack0) req0 = 1'b0;
      if (gnt1 || nack1) req1 = 1'b0;
    end
    check("drain_done", int'(req0 || req1), 0);
    req0 = 1'b0; req1 = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
